// File: rtl/rob_retire_pkg.sv
// rob_retire_pkg: shared types for the reorder-buffer retire block.
//   rob_entry : one ROB slot (valid/complete flags, decode payload, results).
package rob_retire_pkg;

  typedef struct packed {
    logic        valid;
    logic        complete;
    logic [6:0]  rd_opcode;
    logic [5:0]  curr_d_reg;
    logic [5:0]  old_d_reg;
    logic [31:0] rd_value;   // result, or store address
    logic [31:0] rs2_value;  // store data
  } rob_entry;

endpackage

// File: rtl/rob_retire_if.sv
// rob_retire_if: dispatch / completion / retire bundle of the ROB.
//   master : dispatch+execute side (drives flush, alloc_*, cmpl_*)
//   slave  : the ROB (drives alloc_ready/idx, rob_o_*, num_retired, occupancy)
interface rob_retire_if #(
  parameter int PTR_W = 4
);
  import rob_retire_pkg::*;

  logic             flush;
  logic [1:0]       alloc_cnt;
  rob_entry         alloc_entry_1, alloc_entry_2;
  logic             alloc_ready;
  logic [PTR_W-1:0] alloc_idx_1, alloc_idx_2;
  logic             cmpl_valid_1, cmpl_valid_2;
  logic [PTR_W-1:0] cmpl_idx_1, cmpl_idx_2;
  logic [31:0]      cmpl_rd_value_1, cmpl_rd_value_2;
  logic [31:0]      cmpl_rs2_value_1, cmpl_rs2_value_2;
  rob_entry         rob_o_1, rob_o_2;
  logic [1:0]       num_retired;
  logic [PTR_W:0]   rob_count;
  logic             rob_empty, rob_full;

  modport master (
    output flush, alloc_cnt, alloc_entry_1, alloc_entry_2,
           cmpl_valid_1, cmpl_valid_2, cmpl_idx_1, cmpl_idx_2,
           cmpl_rd_value_1, cmpl_rd_value_2, cmpl_rs2_value_1, cmpl_rs2_value_2,
    input  alloc_ready, alloc_idx_1, alloc_idx_2, rob_o_1, rob_o_2,
           num_retired, rob_count, rob_empty, rob_full
  );

  modport slave (
    input  flush, alloc_cnt, alloc_entry_1, alloc_entry_2,
           cmpl_valid_1, cmpl_valid_2, cmpl_idx_1, cmpl_idx_2,
           cmpl_rd_value_1, cmpl_rd_value_2, cmpl_rs2_value_1, cmpl_rs2_value_2,
    output alloc_ready, alloc_idx_1, alloc_idx_2, rob_o_1, rob_o_2,
           num_retired, rob_count, rob_empty, rob_full
  );

endinterface

// File: rtl/rob_retire.sv
// rob_retire: circular reorder buffer, 2-wide allocate / complete / retire.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : rob_retire_if.slave
//     flush, alloc_cnt/alloc_entry_x in; alloc_ready, alloc_idx_x out
//     cmpl_valid_x/idx_x/rd_value_x/rs2_value_x in (port 2 wins on same idx)
//     rob_o_x, num_retired out (registered, oldest first, zero when idle)
//     rob_count, rob_empty, rob_full out (from registered count)
module rob_retire
  import rob_retire_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int PTR_W = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  rob_retire_if.slave bus
);

  localparam logic [PTR_W:0] DEPTH_C = (PTR_W+1)'(DEPTH);

  rob_entry [DEPTH-1:0] ent_q, ent_d;
  logic [PTR_W-1:0]     head_q, head_d, tail_q, tail_d;
  logic [PTR_W:0]       count_q, count_d;
  rob_entry             out1_q, out1_d, out2_q, out2_d;
  logic [1:0]           nret_q, nret_d;

  logic [PTR_W-1:0] head_p1, tail_p1;
  logic [PTR_W:0]   free_slots;
  logic             alloc_ok, ret1, ret2;
  logic [1:0]       acc_cnt;
  rob_entry         new1, new2;

  assign head_p1    = head_q + 1'b1;
  assign tail_p1    = tail_q + 1'b1;
  // Space comes only from the registered count: a retirement this cycle
  // does not make room for an allocation in the same cycle.
  assign free_slots = DEPTH_C - count_q;
  assign alloc_ok   = (bus.alloc_cnt != 2'd3) &&
                      ((PTR_W+1)'(bus.alloc_cnt) <= free_slots);
  assign acc_cnt    = alloc_ok ? bus.alloc_cnt : 2'd0;

  // In-order retirement: head+1 may only go together with head.
  assign ret1 = ent_q[head_q].valid && ent_q[head_q].complete;
  assign ret2 = ret1 && ent_q[head_p1].valid && ent_q[head_p1].complete;

  // Dispatch payload becomes a fresh, not-yet-complete slot.
  always_comb begin
    new1           = bus.alloc_entry_1;
    new1.valid     = 1'b1;
    new1.complete  = 1'b0;
    new1.rd_value  = '0;
    new1.rs2_value = '0;
    new2           = bus.alloc_entry_2;
    new2.valid     = 1'b1;
    new2.complete  = 1'b0;
    new2.rd_value  = '0;
    new2.rs2_value = '0;
  end

  always_comb begin
    ent_d   = ent_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    out1_d  = '0;
    out2_d  = '0;
    nret_d  = 2'd0;
    if (bus.flush) begin
      ent_d   = '0;
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      // Validity is checked on registered state, so a completion aimed at a
      // slot being allocated this cycle is dropped. Port 2 is applied last.
      if (bus.cmpl_valid_1 && ent_q[bus.cmpl_idx_1].valid) begin
        ent_d[bus.cmpl_idx_1].complete  = 1'b1;
        ent_d[bus.cmpl_idx_1].rd_value  = bus.cmpl_rd_value_1;
        ent_d[bus.cmpl_idx_1].rs2_value = bus.cmpl_rs2_value_1;
      end
      if (bus.cmpl_valid_2 && ent_q[bus.cmpl_idx_2].valid) begin
        ent_d[bus.cmpl_idx_2].complete  = 1'b1;
        ent_d[bus.cmpl_idx_2].rd_value  = bus.cmpl_rd_value_2;
        ent_d[bus.cmpl_idx_2].rs2_value = bus.cmpl_rs2_value_2;
      end
      if (ret1) begin
        out1_d        = ent_q[head_q];
        ent_d[head_q] = '0;
      end
      if (ret2) begin
        out2_d         = ent_q[head_p1];
        ent_d[head_p1] = '0;
      end
      // Accepted allocations land on free slots, never on a retiring head.
      if (acc_cnt != 2'd0) ent_d[tail_q]  = new1;
      if (acc_cnt == 2'd2) ent_d[tail_p1] = new2;
      nret_d  = {1'b0, ret1} + {1'b0, ret2};
      head_d  = head_q + PTR_W'(nret_d);
      tail_d  = tail_q + PTR_W'(acc_cnt);
      count_d = count_q + (PTR_W+1)'(acc_cnt) - (PTR_W+1)'(nret_d);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ent_q   <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      out1_q  <= '0;
      out2_q  <= '0;
      nret_q  <= 2'd0;
    end else begin
      ent_q   <= ent_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      out1_q  <= out1_d;
      out2_q  <= out2_d;
      nret_q  <= nret_d;
    end
  end

  assign bus.rob_o_1     = out1_q;
  assign bus.rob_o_2     = out2_q;
  assign bus.num_retired = nret_q;
  assign bus.rob_count   = count_q;
  assign bus.rob_empty   = (count_q == '0);
  assign bus.rob_full    = (count_q == DEPTH_C);
  assign bus.alloc_ready = (count_q <= DEPTH_C - 2'd2);
  assign bus.alloc_idx_1 = tail_q;
  assign bus.alloc_idx_2 = tail_p1;

endmodule

// File: tb/tb_rob_retire.sv
// tb_rob_retire: self-checking bench for rob_retire.
// Allocations are recorded in program order; each retirement popped from
// that queue must match the retiring rob_o slot bit for bit.
module tb_rob_retire;
  import rob_retire_pkg::*;

  localparam int DEPTH = 16;
  localparam int PTR_W = 4;
  localparam logic [6:0] OP_ALU   = 7'b0110011;
  localparam logic [6:0] OP_STORE = 7'b0100011;

  logic clk, rst_n;

  rob_retire_if #(.PTR_W(PTR_W)) bus ();

  rob_retire #(.DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int nvec = 0;
  int nerr = 0;

  rob_entry         m_ent [DEPTH];
  bit               m_valid [DEPTH];
  int               sb_q [$];
  logic [PTR_W-1:0] m_tail;

  typedef struct {
    int fl, acnt, d1, d2, c1v, c1i, c2v, c2i, acc;
    int x_nret, x_cnt, x_tail, x_r1, x_r2;
  } vec_t;

  vec_t tbl [15];
  vec_t v;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk_state(input string tag, input int cnt, input int nret, input int tail);
    chk({tag, " rob_count"},   bus.rob_count,   cnt);
    chk({tag, " rob_empty"},   bus.rob_empty,   cnt == 0);
    chk({tag, " rob_full"},    bus.rob_full,    cnt == DEPTH);
    chk({tag, " alloc_ready"}, bus.alloc_ready, cnt <= DEPTH - 2);
    chk({tag, " num_retired"}, bus.num_retired, nret);
    chk({tag, " alloc_idx_1"}, bus.alloc_idx_1, tail % DEPTH);
    chk({tag, " alloc_idx_2"}, bus.alloc_idx_2, (tail + 1) % DEPTH);
  endtask

  task automatic idle_in();
    bus.flush = 1'b0;
    bus.alloc_cnt = 2'd0;
    bus.alloc_entry_1 = '0;
    bus.alloc_entry_2 = '0;
    bus.cmpl_valid_1 = 1'b0;
    bus.cmpl_valid_2 = 1'b0;
    bus.cmpl_idx_1 = '0;
    bus.cmpl_idx_2 = '0;
    bus.cmpl_rd_value_1 = '0;
    bus.cmpl_rd_value_2 = '0;
    bus.cmpl_rs2_value_1 = '0;
    bus.cmpl_rs2_value_2 = '0;
  endtask

  task automatic set_alloc(input logic [1:0] n, input logic [5:0] d1, input logic [5:0] d2,
                           input logic [6:0] op);
    bus.alloc_cnt = n;
    bus.alloc_entry_1 = '0;
    bus.alloc_entry_1.rd_opcode  = op;
    bus.alloc_entry_1.curr_d_reg = d1;
    bus.alloc_entry_1.old_d_reg  = d1 ^ 6'h20;
    bus.alloc_entry_2 = '0;
    bus.alloc_entry_2.rd_opcode  = op;
    bus.alloc_entry_2.curr_d_reg = d2;
    bus.alloc_entry_2.old_d_reg  = d2 ^ 6'h20;
  endtask

  task automatic set_cmpl(input int port, input logic [3:0] idx,
                          input logic [31:0] rd, input logic [31:0] rs2);
    if (port == 1) begin
      bus.cmpl_valid_1 = 1'b1; bus.cmpl_idx_1 = idx;
      bus.cmpl_rd_value_1 = rd; bus.cmpl_rs2_value_1 = rs2;
    end else begin
      bus.cmpl_valid_2 = 1'b1; bus.cmpl_idx_2 = idx;
      bus.cmpl_rd_value_2 = rd; bus.cmpl_rs2_value_2 = rs2;
    end
  endtask

  task automatic model_clear();
    sb_q.delete();
    for (int i = 0; i < DEPTH; i++) begin
      m_valid[i] = 1'b0;
      m_ent[i] = '0;
    end
    m_tail = '0;
  endtask

  task automatic add_entry(input rob_entry e);
    m_ent[m_tail] = '{valid: 1'b1, complete: 1'b0, rd_opcode: e.rd_opcode,
                      curr_d_reg: e.curr_d_reg, old_d_reg: e.old_d_reg,
                      rd_value: 32'h0, rs2_value: 32'h0};
    m_valid[m_tail] = 1'b1;
    sb_q.push_back(int'(m_tail));
    m_tail = m_tail + 1'b1;
  endtask

  task automatic pop_exp(input string nm, output rob_entry e);
    int idx;
    e = '0;
    if (sb_q.size() == 0) begin
      nvec++; nerr++;
      $display("FAIL %s: retirement reported with no outstanding entry", nm);
    end else begin
      idx = sb_q.pop_front();
      e = m_ent[idx];
      m_valid[idx] = 1'b0;
    end
  endtask

  // One clock: update the model from the driven inputs, clock, then compare
  // any retirement against the scoreboard and return inputs to idle.
  task automatic tick(input bit acc);
    rob_entry e1, e2;
    if (bus.flush) begin
      model_clear();
    end else begin
      if (bus.cmpl_valid_1 && m_valid[bus.cmpl_idx_1]) begin
        m_ent[bus.cmpl_idx_1].complete  = 1'b1;
        m_ent[bus.cmpl_idx_1].rd_value  = bus.cmpl_rd_value_1;
        m_ent[bus.cmpl_idx_1].rs2_value = bus.cmpl_rs2_value_1;
      end
      if (bus.cmpl_valid_2 && m_valid[bus.cmpl_idx_2]) begin
        m_ent[bus.cmpl_idx_2].complete  = 1'b1;
        m_ent[bus.cmpl_idx_2].rd_value  = bus.cmpl_rd_value_2;
        m_ent[bus.cmpl_idx_2].rs2_value = bus.cmpl_rs2_value_2;
      end
      if (acc) begin
        add_entry(bus.alloc_entry_1);
        if (bus.alloc_cnt == 2'd2) add_entry(bus.alloc_entry_2);
      end
    end
    @(posedge clk);
    #1;
    e1 = '0; e2 = '0;
    if (bus.num_retired >= 2'd1) pop_exp("sb_pop1", e1);
    if (bus.num_retired == 2'd2) pop_exp("sb_pop2", e2);
    chk("sb rob_o_1", bus.rob_o_1, e1);
    chk("sb rob_o_2", bus.rob_o_2, e2);
    idle_in();
  endtask

  task automatic do_reset();
    idle_in();
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #2;
    chk_state("reset", 0, 0, 0);
    chk("reset rob_o_1", bus.rob_o_1, 0);
    chk("reset rob_o_2", bus.rob_o_2, 0);
    model_clear();
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    //         fl acnt d1 d2 c1v c1i c2v c2i acc | nret cnt tail r1 r2
    tbl[0]  = '{0, 2,  5, 6,  0, 0,  0, 0,  1,    0, 2, 2,  0, 0};
    tbl[1]  = '{0, 0,  0, 0,  1, 1,  0, 0,  0,    0, 2, 2,  0, 0};
    tbl[2]  = '{0, 0,  0, 0,  0, 0,  0, 0,  0,    0, 2, 2,  0, 0};
    tbl[3]  = '{0, 0,  0, 0,  1, 0,  0, 0,  0,    0, 2, 2,  0, 0};
    tbl[4]  = '{0, 0,  0, 0,  0, 0,  0, 0,  0,    2, 0, 2,  5, 6};
    tbl[5]  = '{0, 0,  0, 0,  0, 0,  0, 0,  0,    0, 0, 2,  0, 0};
    tbl[6]  = '{0, 1,  7, 0,  1, 2,  0, 0,  1,    0, 1, 3,  0, 0};
    tbl[7]  = '{0, 0,  0, 0,  0, 0,  0, 0,  0,    0, 1, 3,  0, 0};
    tbl[8]  = '{0, 0,  0, 0,  1, 2,  1, 2,  0,    0, 1, 3,  0, 0};
    tbl[9]  = '{0, 0,  0, 0,  0, 0,  0, 0,  0,    1, 0, 3,  7, 0};
    tbl[10] = '{0, 3,  8, 9,  0, 0,  0, 0,  0,    0, 0, 3,  0, 0};
    tbl[11] = '{0, 2, 10, 11, 0, 0,  1, 3,  1,    0, 2, 5,  0, 0};
    tbl[12] = '{0, 0,  0, 0,  1, 4,  0, 0,  0,    0, 2, 5,  0, 0};
    tbl[13] = '{0, 0,  0, 0,  0, 0,  1, 3,  0,    0, 2, 5,  0, 0};
    tbl[14] = '{0, 0,  0, 0,  0, 0,  0, 0,  0,    2, 0, 5, 10, 11};

    do_reset();

    for (int i = 0; i < 15; i++) begin
      v = tbl[i];
      bus.flush = (v.fl != 0);
      if (v.acnt != 0) set_alloc(2'(v.acnt), 6'(v.d1), 6'(v.d2), OP_ALU);
      if (v.c1v != 0) set_cmpl(1, 4'(v.c1i), 32'(32'h1000 + v.c1i), 32'(32'h2000 + v.c1i));
      if (v.c2v != 0) set_cmpl(2, 4'(v.c2i), 32'(32'h3000 + v.c2i), 32'(32'h4000 + v.c2i));
      tick(v.acc != 0);
      chk_state($sformatf("vec%0d", i), v.x_cnt, v.x_nret, v.x_tail);
      chk($sformatf("vec%0d r1 curr", i), bus.rob_o_1.curr_d_reg, v.x_r1);
      chk($sformatf("vec%0d r2 curr", i), bus.rob_o_2.curr_d_reg, v.x_r2);
    end

    // Fill to DEPTH; slot j carries curr_d_reg 20+j.
    do_reset();
    for (int i = 0; i < 8; i++) begin
      set_alloc(2'd2, 6'(20 + 2*i), 6'(21 + 2*i), OP_ALU);
      tick(1'b1);
      chk_state($sformatf("fill%0d", i), 2*(i+1), 0, 2*(i+1));
    end
    set_alloc(2'd1, 6'd63, 6'd0, OP_ALU);
    tick(1'b0);
    chk_state("full drop", 16, 0, 0);

    // count=15 with two retiring and alloc_cnt=2: dropped, count -> 13.
    set_cmpl(1, 4'd0, 32'h5000, 32'h6000);
    tick(1'b0);
    chk_state("c24 a", 16, 0, 0);
    set_cmpl(1, 4'd1, 32'h5001, 32'h6001);
    set_cmpl(2, 4'd2, 32'h5002, 32'h6002);
    tick(1'b0);
    chk_state("c24 b", 15, 1, 0);
    set_alloc(2'd2, 6'd50, 6'd51, OP_ALU);
    tick(1'b0);
    chk_state("c24 c", 13, 2, 0);

    // Drain 3..14 so head reaches 15, then retire 15 and 0 together.
    for (int i = 0; i < 6; i++) begin
      set_cmpl(1, 4'(3 + 2*i), 32'(32'h5000 + 3 + 2*i), 32'(32'h6000 + 3 + 2*i));
      set_cmpl(2, 4'(4 + 2*i), 32'(32'h5000 + 4 + 2*i), 32'(32'h6000 + 4 + 2*i));
      tick(1'b0);
    end
    tick(1'b0);
    tick(1'b0);
    chk_state("wrap drained", 1, 0, 0);
    set_alloc(2'd1, 6'd40, 6'd0, OP_ALU);
    tick(1'b1);
    chk_state("wrap alloc", 2, 0, 1);
    set_cmpl(1, 4'd15, 32'h500F, 32'h600F);
    set_cmpl(2, 4'd0, 32'h7000, 32'h8000);
    tick(1'b0);
    chk_state("wrap cmpl", 2, 0, 1);
    tick(1'b0);
    chk_state("wrap retire", 0, 2, 1);
    chk("wrap r1 curr", bus.rob_o_1.curr_d_reg, 35);
    chk("wrap r2 curr", bus.rob_o_2.curr_d_reg, 40);
    set_alloc(2'd1, 6'd41, 6'd0, OP_ALU);
    tick(1'b1);
    chk_state("head1 alloc", 1, 0, 2);
    set_cmpl(1, 4'd1, 32'h9001, 32'hA001);
    tick(1'b0);
    chk_state("head1 cmpl", 1, 0, 2);
    tick(1'b0);
    chk_state("head1 retire", 0, 1, 2);
    chk("head1 r1 curr", bus.rob_o_1.curr_d_reg, 41);

    // Store retires like any other entry.
    do_reset();
    set_alloc(2'd1, 6'd12, 6'd0, OP_STORE);
    tick(1'b1);
    chk_state("store alloc", 1, 0, 1);
    set_cmpl(1, 4'd0, 32'h20, 32'hABCD);
    tick(1'b0);
    chk_state("store cmpl", 1, 0, 1);
    tick(1'b0);
    chk_state("store retire", 0, 1, 1);
    chk("store opcode", bus.rob_o_1.rd_opcode, OP_STORE);
    chk("store rd_value", bus.rob_o_1.rd_value, 32'h20);
    chk("store rs2_value", bus.rob_o_1.rs2_value, 32'hABCD);

    // Flush beats a pending retirement, a completion and an allocation.
    set_alloc(2'd2, 6'd50, 6'd51, OP_ALU);
    tick(1'b1);
    chk_state("flush pre a", 2, 0, 3);
    set_cmpl(1, 4'd1, 32'hB001, 32'hC001);
    tick(1'b0);
    chk_state("flush pre b", 2, 0, 3);
    bus.flush = 1'b1;
    set_cmpl(1, 4'd2, 32'hB002, 32'hC002);
    set_alloc(2'd2, 6'd52, 6'd53, OP_ALU);
    tick(1'b0);
    chk_state("flush", 0, 0, 0);
    tick(1'b0);
    chk_state("flush after", 0, 0, 0);

    // Reset mid-operation with completed entries about to retire.
    set_alloc(2'd2, 6'd60, 6'd61, OP_ALU);
    tick(1'b1);
    chk_state("rst pre a", 2, 0, 2);
    set_cmpl(1, 4'd0, 32'hD000, 32'hE000);
    set_cmpl(2, 4'd1, 32'hD001, 32'hE001);
    tick(1'b0);
    chk_state("rst pre b", 2, 0, 2);
    do_reset();
    tick(1'b0);
    chk_state("rst after", 0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
